// File: rtl/aes_pkg.sv
// Shared AES datapath types and GF(2^8) helpers for the MixColumns engine.
// All byte multiplies reduce modulo x^8+x^4+x^3+x+1.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  word_t;

  localparam logic [7:0] GF_POLY = 8'h1B;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mc_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  // Higher multiples are built from the x2/x4/x8 powers.
  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul11(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul13(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gf_mul14(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/mix_word_dual.sv
// Combinational single-column MixColumns / InvMixColumns transform.
// Byte r of the word is row r of the column.
module mix_word_dual
  import aes_pkg::*;
#(
  parameter bit ENABLE_INV = 1'b1
) (
  input  logic [31:0] in_word,
  input  logic        inv,
  output logic [31:0] out_word
);

  logic [7:0] a [4];
  word_t      fwd_w;

  for (genvar r = 0; r < 4; r++) begin : g_row
    assign a[r] = in_word[8*r +: 8];
    assign fwd_w[8*r +: 8] = gf_mul2(a[r]) ^ gf_mul3(a[(r+1)%4]) ^ a[(r+2)%4] ^ a[(r+3)%4];
  end

  if (ENABLE_INV) begin : g_inv
    word_t inv_w;
    for (genvar r = 0; r < 4; r++) begin : g_inv_row
      assign inv_w[8*r +: 8] = gf_mul14(a[r]) ^ gf_mul11(a[(r+1)%4]) ^
                               gf_mul13(a[(r+2)%4]) ^ gf_mul9(a[(r+3)%4]);
    end
    assign out_word = inv ? inv_w : fwd_w;
  end else begin : g_fwd_only
    logic unused_inv;
    assign unused_inv = inv;
    assign out_word   = fwd_w;
  end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative valid/ready MixColumns engine: transforms COLS_PER_CYCLE columns
// of the working register in place per BUSY cycle, with a final-round bypass.
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter int ENABLE_INV     = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  input  logic         in_skip,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  mc_state_e  state_q, state_d;
  logic [1:0] col_idx_q, col_idx_d;
  state_t     work_q, work_d;
  logic       inv_q, inv_d;

  logic [1:0] col_sel [COLS_PER_CYCLE];
  word_t      mix_out [COLS_PER_CYCLE];
  logic       last_step;

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    assign col_sel[k] = col_idx_q + 2'(k);
    mix_word_dual #(.ENABLE_INV(ENABLE_INV != 0)) u_mix (
      .in_word  (work_q[{col_sel[k], 5'b0} +: 32]),
      .inv      (inv_q),
      .out_word (mix_out[k])
    );
  end

  // The last BUSY cycle is the one whose column group ends at column 3.
  assign last_step = (3'(col_idx_q) + 3'(COLS_PER_CYCLE)) == 3'd4;

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    work_d    = work_q;
    inv_d     = inv_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: in_ready = 1'b1;
      BUSY: begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          work_d[{col_sel[k], 5'b0} +: 32] = mix_out[k];
        end
        col_idx_d = col_idx_q + 2'(COLS_PER_CYCLE);
        if (last_step) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // An accept in DONE overlaps the output handshake on the same edge.
    if (in_ready && in_valid) begin
      work_d    = in_data;
      inv_d     = (ENABLE_INV != 0) && in_inv;
      col_idx_d = 2'd0;
      state_d   = in_skip ? DONE : BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      col_idx_q <= 2'd0;
      work_q    <= '0;
      inv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      work_q    <= work_d;
      inv_q     <= inv_d;
    end
  end

  assign out_data = work_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: instances at 1/2/4 columns per cycle plus a
// forward-only build, checked against a polynomial-multiply reference model.
module tb_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid  [4];
  logic         in_ready  [4];
  logic [127:0] in_data   [4];
  logic         in_inv    [4];
  logic         in_skip   [4];
  logic         out_valid [4];
  logic         out_ready [4];
  logic [127:0] out_data  [4];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    mix_columns_iter #(
      .COLS_PER_CYCLE ((g == 0) ? 1 : (g == 2) ? 4 : 2),
      .ENABLE_INV     ((g == 3) ? 0 : 1)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_inv    (in_inv[g]),
      .in_skip   (in_skip[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g])
    );
  end

  function automatic int cpc(input int d);
    return (d == 0) ? 1 : (d == 2) ? 4 : 2;
  endfunction

  // Carry-less multiply followed by long division by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic inv);
    logic [7:0]   fwd_c [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
    logic [7:0]   inv_c [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [127:0] r = '0;
    logic [7:0]   acc;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(inv ? inv_c[(j - row + 4) % 4] : fwd_c[(j - row + 4) % 4],
                           s[32*c + 8*j +: 8]);
        r[32*c + 8*row +: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] expect_out(input int d, input logic [127:0] s,
                                              input logic inv, input logic skip);
    if (skip) return s;
    return ref_mix(s, inv && (d != 3));
  endfunction

  function automatic int expect_lat(input int d, input logic skip);
    return skip ? 1 : (4 / cpc(d)) + 1;
  endfunction

  // Presents one state, waits for the accept edge, then counts edges to out_valid.
  task automatic send(input int d, input logic [127:0] data, input logic inv,
                      input logic skip, output int lat);
    int guard = 0;
    @(negedge clk);
    in_data[d] = data; in_inv[d] = inv; in_skip[d] = skip; in_valid[d] = 1'b1;
    while (!in_ready[d] && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    in_valid[d] = 1'b0;
    lat = 1;
    while (!out_valid[d] && lat < 40) begin @(negedge clk); lat++; end
  endtask

  task automatic handshake(input int d);
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      tests++;
      if (out_valid[d] !== 1'b0) begin
        $display("[TB] FAIL reset_out_valid dut%0d got %b want 0", d, out_valid[d]); fails++;
      end
      tests++;
      if (out_data[d] !== 128'h0) begin
        $display("[TB] FAIL reset_out_data dut%0d got %h want 0", d, out_data[d]); fails++;
      end
      tests++;
      if (in_ready[d] !== 1'b1) begin
        $display("[TB] FAIL reset_in_ready dut%0d got %b want 1", d, in_ready[d]); fails++;
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_forward_vector;
    int lat;
    logic [127:0] want = {4{32'hbca14d8e}};
    send(0, {4{32'h455313db}}, 1'b0, 1'b0, lat);
    tests++;
    if (lat != 5) begin $display("[TB] FAIL fwd_latency got %0d want 5", lat); fails++; end
    tests++;
    if (out_data[0] !== want) begin
      $display("[TB] FAIL fwd_vector got %h want %h", out_data[0], want); fails++;
    end
    handshake(0);
  endtask

  task automatic test_inverse_vector;
    int lat;
    logic [127:0] din  = {32'hc6c6c6c6, 32'h01010101, 32'h9d58dc9f, 32'hbca14d8e};
    logic [127:0] want = {32'hc6c6c6c6, 32'h01010101, 32'h5c220af2, 32'h455313db};
    send(2, din, 1'b1, 1'b0, lat);
    tests++;
    if (lat != 2) begin $display("[TB] FAIL inv_latency got %0d want 2", lat); fails++; end
    tests++;
    if (out_data[2] !== want) begin
      $display("[TB] FAIL inv_vector got %h want %h", out_data[2], want); fails++;
    end
    handshake(2);
  endtask

  task automatic test_skip;
    int lat;
    logic [127:0] din = 128'h00112233_44556677_8899aabb_ccddeeff;
    send(1, din, 1'b1, 1'b1, lat);
    tests++;
    if (lat != 1) begin $display("[TB] FAIL skip_latency got %0d want 1", lat); fails++; end
    tests++;
    if (out_data[1] !== din) begin
      $display("[TB] FAIL skip_data got %h want %h", out_data[1], din); fails++;
    end
    handshake(1);
  endtask

  task automatic test_back_to_back;
    int lat;
    bit stable = 1'b1;
    logic [127:0] a = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] b = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] wa = expect_out(0, a, 1'b0, 1'b0);
    logic [127:0] wb = expect_out(0, b, 1'b1, 1'b0);
    send(0, a, 1'b0, 1'b0, lat);
    in_data[0] = b; in_inv[0] = 1'b1; in_skip[0] = 1'b0; in_valid[0] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (out_valid[0] !== 1'b1 || out_data[0] !== wa || in_ready[0] !== 1'b0) stable = 1'b0;
    end
    tests++;
    if (!stable) begin
      $display("[TB] FAIL bp_hold got v=%b d=%h rdy=%b want v=1 d=%h rdy=0",
               out_valid[0], out_data[0], in_ready[0], wa);
      fails++;
    end
    out_ready[0] = 1'b1;
    #1;
    tests++;
    if (in_ready[0] !== 1'b1) begin
      $display("[TB] FAIL bp_in_ready got %b want 1", in_ready[0]); fails++;
    end
    @(negedge clk);
    out_ready[0] = 1'b0;
    in_data[0] = ~b;
    tests++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
      $display("[TB] FAIL b2b_busy got v=%b rdy=%b want v=0 rdy=0", out_valid[0], in_ready[0]);
      fails++;
    end
    lat = 1;
    while (!out_valid[0] && lat < 40) begin @(negedge clk); lat++; end
    in_valid[0] = 1'b0;
    tests++;
    if (lat != 5) begin $display("[TB] FAIL b2b_latency got %0d want 5", lat); fails++; end
    tests++;
    if (out_data[0] !== wb) begin
      $display("[TB] FAIL b2b_data got %h want %h", out_data[0], wb); fails++;
    end
    handshake(0);
  endtask

  task automatic test_reset_mid;
    int lat;
    bit quiet = 1'b1;
    logic [127:0] din = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    in_data[0] = {4{32'hdeadbeef}}; in_inv[0] = 1'b0; in_skip[0] = 1'b0; in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (out_valid[0] !== 1'b0 || out_data[0] !== 128'h0 || in_ready[0] !== 1'b1) begin
      $display("[TB] FAIL midrst_state got v=%b d=%h rdy=%b want v=0 d=0 rdy=1",
               out_valid[0], out_data[0], in_ready[0]);
      fails++;
    end
    repeat (6) begin @(negedge clk); if (out_valid[0] !== 1'b0) quiet = 1'b0; end
    tests++;
    if (!quiet) begin $display("[TB] FAIL midrst_no_emit got valid want quiet"); fails++; end
    send(0, din, 1'b1, 1'b0, lat);
    tests++;
    if (out_data[0] !== expect_out(0, din, 1'b1, 1'b0) || lat != 5) begin
      $display("[TB] FAIL midrst_fresh got %h lat %0d want %h lat 5",
               out_data[0], lat, expect_out(0, din, 1'b1, 1'b0));
      fails++;
    end
    handshake(0);
  endtask

  task automatic test_random;
    int lat, d, bp;
    logic inv, skip;
    logic [127:0] din, want;
    for (int i = 0; i < 1000; i++) begin
      d    = i % 4;
      din  = {$urandom, $urandom, $urandom, $urandom};
      inv  = 1'($urandom_range(0, 1));
      skip = ($urandom_range(0, 3) == 0);
      bp   = $urandom_range(0, 3);
      want = expect_out(d, din, inv, skip);
      send(d, din, inv, skip, lat);
      tests++;
      if (lat != expect_lat(d, skip)) begin
        $display("[TB] FAIL rand_latency #%0d dut%0d got %0d want %0d", i, d, lat, expect_lat(d, skip));
        fails++;
      end
      tests++;
      if (out_data[d] !== want) begin
        $display("[TB] FAIL rand_data #%0d dut%0d got %h want %h", i, d, out_data[d], want);
        fails++;
      end
      repeat (bp) @(negedge clk);
      tests++;
      if (out_valid[d] !== 1'b1 || out_data[d] !== want) begin
        $display("[TB] FAIL rand_hold #%0d dut%0d got v=%b %h want v=1 %h",
                 i, d, out_valid[d], out_data[d], want);
        fails++;
      end
      handshake(d);
    end
  endtask

  task automatic test_round_trip;
    int lat, d;
    logic [127:0] din, mid;
    for (int i = 0; i < 30; i++) begin
      d   = i % 3;
      din = {$urandom, $urandom, $urandom, $urandom};
      send(d, din, 1'b0, 1'b0, lat);
      mid = out_data[d];
      handshake(d);
      send(d, mid, 1'b1, 1'b0, lat);
      tests++;
      if (out_data[d] !== din) begin
        $display("[TB] FAIL round_trip #%0d dut%0d got %h want %h", i, d, out_data[d], din);
        fails++;
      end
      handshake(d);
    end
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin
      in_valid[d] = 1'b0; in_data[d] = '0; in_inv[d] = 1'b0;
      in_skip[d] = 1'b0; out_ready[d] = 1'b0;
    end
    test_reset;
    test_forward_vector;
    test_inverse_vector;
    test_skip;
    test_back_to_back;
    test_reset_mid;
    test_random;
    test_round_trip;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
